// File: rtl/huffman_encoder.sv
// huffman_encoder: upstream stage of the Huffman serial link.
// Buffers 3-bit symbols in a small FIFO and serializes their prefix codes
// MSB-first onto (x, x_valid), one bit per clock. Codes are back-to-back
// when the FIFO is non-empty.
// Optional build macro HUFF_ENC_STATS_EN adds sym_count/bit_count outputs.
module huffman_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] fifo_count
`ifdef HUFF_ENC_STATS_EN
    ,
    output logic [15:0]      sym_count,
    output logic [15:0]      bit_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Code left-aligned in 4 bits plus its length.
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] bits;
    } code_t;

    function automatic code_t code_lookup(input logic [2:0] s);
        code_t c;
        case (s)
            3'b001:  c = '{len: 3'd1, bits: 4'b0000};
            3'b011:  c = '{len: 3'd3, bits: 4'b1000};
            3'b010:  c = '{len: 3'd3, bits: 4'b1010};
            3'b100:  c = '{len: 3'd3, bits: 4'b1110};
            3'b110:  c = '{len: 3'd4, bits: 4'b1100};
            3'b101:  c = '{len: 3'd4, bits: 4'b1101};
            default: c = '{len: 3'd1, bits: 4'b0000}; // never stored
        endcase
        return c;
    endfunction

    // FIFO storage and bookkeeping
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Serializer state
    state_e           state_q, state_d;
    logic [3:0]       shreg_q, shreg_d;
    logic [2:0]       bits_left_q, bits_left_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             err_q, err_d;

    logic             sym_legal;
    logic             accept;
    logic             push;
    logic             pop;
    logic             load;
    logic             fifo_empty;
    code_t            head_code;

    assign sym_legal  = (sym_in != 3'b000) && (sym_in != 3'b111);
    assign fifo_empty = (count_q == '0);
    assign sym_ready  = (count_q != CNT_W'(FIFO_DEPTH)) && reset_n;
    assign accept     = sym_valid && sym_ready;
    assign push       = accept && sym_legal;
    assign head_code  = code_lookup(mem_q[rd_ptr_q]);

    // Serializer next state: load a new code from IDLE or after the last bit,
    // otherwise shift out the next bit.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        x_d         = 1'b0;
        x_valid_d   = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            S_SHIFT: begin
                if (bits_left_q > 3'd1) begin
                    shreg_d     = shreg_q << 1;
                    x_d         = shreg_q[2];
                    x_valid_d   = 1'b1;
                    bits_left_d = bits_left_q - 3'd1;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            shreg_d     = head_code.bits;
            bits_left_d = head_code.len;
            x_d         = head_code.bits[3];
            x_valid_d   = 1'b1;
            state_d     = S_SHIFT;
        end
    end

    assign pop = load;

    // FIFO pointer/occupancy next state and sticky illegal-symbol flag
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | (accept & ~sym_legal);
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            err_q       <= err_d;
        end
    end

    // FIFO storage write
    // NOTE: the storage array has no reset; entries are only read after being
    // written, as guarded by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sym_in;
    end

`ifdef HUFF_ENC_STATS_EN
    logic [15:0] sym_count_q;
    logic [15:0] bit_count_q;

    // Statistics: codes loaded and code bits emitted, both wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            if (load)      sym_count_q <= sym_count_q + 16'd1;
            if (x_valid_q) bit_count_q <= bit_count_q + 16'd1;
        end
    end

    assign sym_count = sym_count_q;
    assign bit_count = bit_count_q;
`endif

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign err        = err_q;
    assign fifo_count = count_q;
    assign busy       = !fifo_empty || (state_q == S_SHIFT);

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed testbench for huffman_encoder with a serial prefix-code decoder
// model listening on (x, x_valid).
module tb_huffman_encoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       err;
    logic [2:0] fifo_count;
`ifdef HUFF_ENC_STATS_EN
    logic [15:0] sym_count;
    logic [15:0] bit_count;
`endif

    huffman_encoder #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .err        (err),
        .fifo_count (fifo_count)
`ifdef HUFF_ENC_STATS_EN
        ,
        .sym_count  (sym_count),
        .bit_count  (bit_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] dec_q[$];
    logic [2:0] exp_q[$];
    logic       bit_q[$];
    int         rises = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decoder model: returns {valid, symbol} for an accumulated prefix.
    function automatic logic [3:0] decode(input logic [3:0] a, input int l);
        logic [3:0] r;
        r = 4'b0000;
        if (l == 1 && a[0] == 1'b0) r = {1'b1, 3'b001};
        else if (l == 3) begin
            case (a[2:0])
                3'b100:  r = {1'b1, 3'b011};
                3'b101:  r = {1'b1, 3'b010};
                3'b111:  r = {1'b1, 3'b100};
                default: r = 4'b0000;
            endcase
        end else if (l == 4) begin
            case (a)
                4'b1100: r = {1'b1, 3'b110};
                4'b1101: r = {1'b1, 3'b101};
                default: r = {1'b1, 3'b000}; // invalid code: marker symbol
            endcase
        end
        return r;
    endfunction

    // Serial decoder / bit monitor sampling on the falling edge
    logic [3:0] acc;
    int         len;
    logic       prev_v;
    always @(negedge clk) begin
        logic [3:0] r;
        if (!reset_n) begin
            acc    = '0;
            len    = 0;
            prev_v = 1'b0;
        end else begin
            if (x_valid) begin
                acc = {acc[2:0], x};
                len++;
                bit_q.push_back(x);
                if (!prev_v) rises++;
                r = decode(acc, len);
                if (r[3]) begin
                    dec_q.push_back(r[2:0]);
                    acc = '0;
                    len = 0;
                end
            end
            prev_v = x_valid;
        end
    end

    task automatic push_sym(input logic [2:0] s, output int waited);
        sym_in    = s;
        sym_valid = 1'b1;
        waited    = 0;
        while (!sym_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!sym_ready) check("push_timeout", {31'd0, sym_ready}, 32'd1);
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("drain_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_dec(input string tag);
        check({tag, "_count"}, dec_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
            check({tag, "_sym"}, {29'd0, dec_q[i]}, {29'd0, exp_q[i]});
    endtask

    task automatic clear_logs();
        dec_q.delete();
        bit_q.delete();
        rises = 0;
    endtask

    initial begin
        int         w;
        int         mism;
        logic [9:0] packed_bits;
        logic [2:0] legal [6];
        logic [2:0] sent_q[$];
        logic [2:0] s;

        legal[0] = 3'b001; legal[1] = 3'b011; legal[2] = 3'b010;
        legal[3] = 3'b100; legal[4] = 3'b110; legal[5] = 3'b101;

        reset_n   = 1'b0;
        sym_valid = 1'b0;
        sym_in    = 3'b000;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready",   {31'd0, sym_ready},  32'd0);
        check("rst_x_valid", {31'd0, x_valid},    32'd0);
        check("rst_x",       {31'd0, x},          32'd0);
        check("rst_busy",    {31'd0, busy},       32'd0);
        check("rst_err",     {31'd0, err},        32'd0);
        check("rst_count",   {29'd0, fifo_count}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("rel_ready",   {31'd0, sym_ready},  32'd1);
        @(negedge clk);

        // Single symbol 001: one-bit code during E1..E2
        clear_logs();
        push_sym(3'b001, w);
        check("single_count_n1", {29'd0, fifo_count}, 32'd1);
        check("single_xv_n1",    {31'd0, x_valid},    32'd0);
        check("single_busy_n1",  {31'd0, busy},       32'd1);
        @(negedge clk);
        check("single_xv_n2",    {31'd0, x_valid},    32'd1);
        check("single_x_n2",     {31'd0, x},          32'd0);
        check("single_count_n2", {29'd0, fifo_count}, 32'd0);
        @(negedge clk);
        check("single_xv_n3",    {31'd0, x_valid},    32'd0);
        check("single_busy_n3",  {31'd0, busy},       32'd0);
        check("single_nbits",    bit_q.size(),        32'd1);

        // Back-to-back 011, 110, 100 -> 1001100111 without gaps
        clear_logs();
        push_sym(3'b011, w);
        push_sym(3'b110, w);
        push_sym(3'b100, w);
        wait_idle();
        packed_bits = '0;
        foreach (bit_q[i]) packed_bits = {packed_bits[8:0], bit_q[i]};
        check("b2b_nbits", bit_q.size(), 32'd10);
        check("b2b_bits",  {22'd0, packed_bits}, {22'd0, 10'b1001100111});
        check("b2b_runs",  rises, 32'd1);
        exp_q = '{3'b011, 3'b110, 3'b100};
        check_dec("b2b_dec");

        // Full FIFO: 101 then six more pushed as fast as allowed
        clear_logs();
        push_sym(3'b101, w);
        check("full_count_1", {29'd0, fifo_count}, 32'd1);
        push_sym(3'b011, w);
        check("full_count_2", {29'd0, fifo_count}, 32'd1);
        push_sym(3'b010, w);
        check("full_count_3", {29'd0, fifo_count}, 32'd2);
        push_sym(3'b100, w);
        check("full_count_4", {29'd0, fifo_count}, 32'd3);
        push_sym(3'b110, w);
        check("full_count_5", {29'd0, fifo_count}, 32'd4);
        check("full_ready_5", {31'd0, sym_ready},  32'd0);
        push_sym(3'b001, w);
        check("full_wait_6",  w, 32'd1);
        check("full_count_6", {29'd0, fifo_count}, 32'd4);
        check("full_ready_6", {31'd0, sym_ready},  32'd0);
        push_sym(3'b011, w);
        check("full_wait_7",  w, 32'd2);
        check("full_count_7", {29'd0, fifo_count}, 32'd4);
        wait_idle();
        exp_q = '{3'b101, 3'b011, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011};
        check_dec("full_dec");
        check("full_runs", rises, 32'd1);

        // Illegal symbols complete the handshake but are dropped
        clear_logs();
        check("ill_err_before", {31'd0, err}, 32'd0);
        push_sym(3'b000, w);
        check("ill0_wait",  w, 32'd0);
        check("ill0_count", {29'd0, fifo_count}, 32'd0);
        check("ill0_xv",    {31'd0, x_valid},    32'd0);
        check("ill0_err",   {31'd0, err},        32'd1);
        push_sym(3'b111, w);
        check("ill7_wait",  w, 32'd0);
        check("ill7_count", {29'd0, fifo_count}, 32'd0);
        check("ill7_xv",    {31'd0, x_valid},    32'd0);
        check("ill7_busy",  {31'd0, busy},       32'd0);
        push_sym(3'b100, w);
        wait_idle();
        check("ill_err_sticky", {31'd0, err}, 32'd1);
        exp_q = '{3'b100};
        check_dec("ill_dec");

        // Reset in the middle of a code
        clear_logs();
        push_sym(3'b110, w);
        push_sym(3'b001, w);
        @(negedge clk);
        check("mid_xv",    {31'd0, x_valid},    32'd1);
        check("mid_x",     {31'd0, x},          32'd1);
        check("mid_count", {29'd0, fifo_count}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_xv",    {31'd0, x_valid},    32'd0);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_ready", {31'd0, sym_ready},  32'd0);
        check("mid_rst_busy",  {31'd0, busy},       32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, sym_ready}, 32'd1);
        check("mid_rel_err",   {31'd0, err},       32'd0);
        @(negedge clk);
        clear_logs();
        push_sym(3'b001, w);
        wait_idle();
        check("mid_after_nbits", bit_q.size(), 32'd1);
        exp_q = '{3'b001};
        check_dec("mid_after_dec");

        // Loopback: 1000 random legal symbols through the decoder model
        clear_logs();
        for (int i = 0; i < 1000; i++) begin
            s = legal[$urandom_range(0, 5)];
            sent_q.push_back(s);
            push_sym(s, w);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        wait_idle();
        check("loop_count", dec_q.size(), 32'd1000);
        mism = 0;
        for (int i = 0; i < sent_q.size() && i < dec_q.size(); i++)
            if (dec_q[i] !== sent_q[i]) mism++;
        check("loop_mismatches", mism, 32'd0);
        check("loop_err", {31'd0, err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
- Upstream stage of the Huffman serial link. Accepts 3-bit symbols over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each symbol's prefix code MSB-first onto a 1-bit stream (x, x_valid), one bit per clock.
- The code table matches the downstream serial Huffman decoder: the decoder consumes x in every cycle where x_valid=1.

Parameters:
- FIFO_DEPTH, 4, number of symbol entries in the input FIFO. Must be a power of 2, 2..16.
- CNT_W, 3, width of fifo_count. Must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sym_in  input  3  symbol to encode.
- sym_valid  input  1  sym_in is valid.
- sym_ready  output  1  block can accept a symbol this cycle.
- x  output  1  serial code bit, registered.
- x_valid  output  1  x carries a code bit this cycle, registered.
- busy  output  1  FIFO non-empty or serializer mid-code.
- err  output  1  sticky flag: an illegal symbol was accepted.
- fifo_count  output  CNT_W  current FIFO occupancy.

Behaviour:
- Code table (symbol -> bits, MSB first):
  - 001 -> 0
  - 011 -> 100
  - 010 -> 101
  - 100 -> 111
  - 110 -> 1100
  - 101 -> 1101
- Symbols 000 and 111 are illegal.
- Reset values (reset_n low, asynchronous): FIFO empty, fifo_count=0, FSM=IDLE, x=0, x_valid=0, busy=0, err=0. sym_ready is forced 0 while reset_n=0.
- Handshake:
  - sym_ready = (fifo_count != FIFO_DEPTH) and reset_n.
  - Transfer occurs at a rising edge where sym_valid and sym_ready are both 1.
  - sym_valid without sym_ready: no transfer. The source holds its data.
- Illegal symbol: the transfer completes but nothing is written to the FIFO, err sets to 1, and only reset clears it.
- FSM states: IDLE, SHIFT.
  - IDLE, FIFO non-empty: pop the head, load the code left-aligned into the 4-bit shift register, load bits_left = code length, drive x = code MSB and x_valid=1, go to SHIFT.
  - IDLE, FIFO empty: x=0, x_valid=0, stay in IDLE.
  - SHIFT, bits_left > 1: shift left, x = next bit, decrement bits_left.
  - SHIFT, last bit: if the FIFO is non-empty, pop and load the next code on the same edge with no bubble; x_valid stays 1. Otherwise x=0, x_valid=0, go to IDLE.
- Latency:
  - Symbol accepted at edge E0 into an idle, empty block: first bit is on x during E1..E2.
  - An N-bit code occupies exactly N consecutive x_valid cycles.
- Simultaneous push and pop on one edge: fifo_count unchanged, data order preserved.
- Push while full: blocked by sym_ready=0, even if a pop occurs on that edge.
- FIFO read/write pointers wrap modulo FIFO_DEPTH.
- busy = (fifo_count != 0) or (FSM == SHIFT).
- Reset mid-code: the partial code is abandoned and x_valid drops immediately. The downstream decoder must be reset together with this block.

Optional Feature:
- Macro: HUFF_ENC_STATS_EN.
- When defined, two extra outputs exist:
  - sym_count [15:0]: increments once per code loaded into the shift register.
  - bit_count [15:0]: increments every cycle x_valid=1.
  - Both reset to 0 and wrap at 16'hFFFF -> 0.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Single symbol: reset, push 001 at E0 -> x_valid=1, x=0 during E1..E2 only; then x_valid=0, busy=0.
- Back-to-back: push 011, 110, 100 on consecutive cycles -> x = 1,0,0,1,1,0,0,1,1,1 with x_valid high for 10 consecutive cycles, no gaps.
- Full FIFO (FIFO_DEPTH=4): push 101 then six more legal symbols on consecutive cycles without waiting.
  - sym_ready drops when fifo_count reaches 4 and returns 1 one cycle after the next pop.
  - No symbol is lost or duplicated.
- Illegal symbols: push 000 then 111 -> both handshakes complete, fifo_count stays 0, x_valid stays 0, err=1 and remains 1 after further legal traffic.
- Reset mid-code: push 110, assert reset_n=0 after 2 bits -> x_valid=0 and fifo_count=0 immediately; after release, sym_ready=1 and the next push of 001 encodes normally.
- Loopback: drive x into the decoder on cycles with x_valid=1, and stream all six legal symbols in random order for 1000 symbols -> the decoded symbol sequence equals the input sequence.
